ocx_tlx_rsp_fifo_ctl: RTL and testbench

Controller wrapped around the TLX framer response FIFO (59-bit entries, 32 deep).
- Write side: round-robin arbitration of NUM_REQ response sources into the FIFO write port, with no-overflow back-pressure.
- Read side: a small state machine presents FIFO head entries to the framer, only while TL response credits returned by the host are available.
- Collects sticky error flags.

---
 rtl/ocx_tlx_rsp_pkg.sv | 26 ++
 rtl/ocx_tlx_rsp_fifo_ctl_if.sv | 66 ++++++
 rtl/ocx_tlx_rr_arb.sv | 73 +++++++
 rtl/ocx_tlx_rsp_fifo_ctl.sv | 183 ++++++++++++++++++
 tb/tb_ocx_tlx_rsp_fifo_ctl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/ocx_tlx_rsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ocx_tlx_rsp_pkg
// Description : Shared definitions for the TLX response FIFO controller.
//               Holds the read-side state encoding and the bit positions
//               of the sticky error vector.
// Revision    : 1.0 - initial release
// ============================================================================
package ocx_tlx_rsp_pkg;

    // Read-side presentation state machine
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRESENT = 2'b01,
        ST_HALT    = 2'b10
    } rsp_state_t;

    // err_sticky bit positions
    localparam int c_ERR_W              = 4;
    localparam int c_ERR_FIFO_UNDERFLOW = 0;
    localparam int c_ERR_FIFO_OVERFLOW  = 1;
    localparam int c_ERR_CREDIT_OVFL    = 2;
    localparam int c_ERR_TAKEN_NO_VALID = 3;

endpackage : ocx_tlx_rsp_pkg
`default_nettype wire

// File: rtl/ocx_tlx_rsp_fifo_ctl_if.sv
`default_nettype none
// ============================================================================
// Module      : ocx_tlx_rsp_fifo_ctl_if
// Description : Bundles the requester, FIFO, host-credit and framer signals
//               of the TLX response FIFO controller.
//               slave  : view of the controller itself
//               master : view of the surrounding environment
// Revision    : 1.0 - initial release
// ============================================================================
interface ocx_tlx_rsp_fifo_ctl_if #(
    parameter int NUM_REQ      = 3,
    parameter int DATA_WIDTH   = 59,
    parameter int CNT_WIDTH    = 6,
    parameter int CREDIT_WIDTH = 8
);
    // requesters
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ack;
    // FIFO write / read ports
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_wr_enable;
    logic [DATA_WIDTH-1:0]         fifo_data_out;
    logic                          fifo_rd_done;
    logic                          fifo_data_available;
    logic [CNT_WIDTH-1:0]          fifo_valid_entry_count;
    logic                          fifo_underflow_error;
    logic                          fifo_overflow_error;
    // host credits
    logic                          tl_credit_return;
    logic [3:0]                    tl_credit_count;
    // framer
    logic                          rsp_halt;
    logic                          rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          rsp_taken;
    // status
    logic [CREDIT_WIDTH-1:0]       credits_avail;
    logic [3:0]                    err_sticky;

    modport slave (
        input  req_valid, req_data,
        output req_ack,
        output fifo_data_in, fifo_wr_enable, fifo_rd_done,
        input  fifo_data_out, fifo_data_available, fifo_valid_entry_count,
        input  fifo_underflow_error, fifo_overflow_error,
        input  tl_credit_return, tl_credit_count,
        input  rsp_halt, rsp_taken,
        output rsp_valid, rsp_data,
        output credits_avail, err_sticky
    );

    modport master (
        output req_valid, req_data,
        input  req_ack,
        input  fifo_data_in, fifo_wr_enable, fifo_rd_done,
        output fifo_data_out, fifo_data_available, fifo_valid_entry_count,
        output fifo_underflow_error, fifo_overflow_error,
        output tl_credit_return, tl_credit_count,
        output rsp_halt, rsp_taken,
        input  rsp_valid, rsp_data,
        input  credits_avail, err_sticky
    );

endinterface : ocx_tlx_rsp_fifo_ctl_if
`default_nettype wire

// File: rtl/ocx_tlx_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : ocx_tlx_rr_arb
// Description : NUM_REQ-way round-robin arbiter with zero-latency grant.
//               Searches upward from the pointer (with wrap) for the first
//               active request; after a grant the pointer moves one past the
//               winner, otherwise it holds.
// Ports       : clock, reset (async, active-high)
//               req[NUM_REQ]     request vector
//               enable           grant permitted this cycle
//               grant[NUM_REQ]   one-hot grant
//               grant_idx        index of the granted requester
//               grant_valid      a grant was issued
// Revision    : 1.0 - initial release
// ============================================================================
module ocx_tlx_rr_arb #(
    parameter  int NUM_REQ = 3,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  wire logic               clock,
    input  wire logic               reset,
    input  wire logic [NUM_REQ-1:0] req,
    input  wire logic               enable,
    output logic      [NUM_REQ-1:0] grant,
    output logic      [IDX_W-1:0]   grant_idx,
    output logic                    grant_valid
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]   r_ptr;
    logic               w_found;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_cand_idx;
    logic [NUM_REQ-1:0] w_grant;
    int                 w_cand;

    always_comb begin
        w_found    = 1'b0;
        w_idx      = '0;
        w_cand     = 0;
        w_cand_idx = '0;
        w_grant    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_cand = int'(r_ptr) + off;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_cand_idx = IDX_W'(w_cand);
            if (!w_found && req[w_cand_idx]) begin
                w_found = 1'b1;
                w_idx   = w_cand_idx;
            end
        end
        if (enable && w_found) begin
            w_grant[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (enable && w_found) begin
            r_ptr <= (w_idx == c_LAST_IDX) ? '0 : w_idx + IDX_W'(1);
        end
    end

    assign grant       = w_grant;
    assign grant_idx   = w_idx;
    assign grant_valid = enable & w_found;

endmodule : ocx_tlx_rr_arb
`default_nettype wire

// File: rtl/ocx_tlx_rsp_fifo_ctl.sv
`default_nettype none
// ============================================================================
// Module      : ocx_tlx_rsp_fifo_ctl
// Description : Controller around the TLX framer response FIFO.
//               - Write side: round-robin arbitration of NUM_REQ sources into
//                 the FIFO write port, blocked while the FIFO is full.
//               - Read side: presents the FIFO head to the framer only while
//                 TL response credits are available.
//               - Collects sticky error flags.
// Ports       : clock, reset (async, active-high)
//               bus (slave modport): requester, FIFO, credit, framer and
//               status signals
// Revision    : 1.0 - initial release
// ============================================================================
module ocx_tlx_rsp_fifo_ctl
    import ocx_tlx_rsp_pkg::*;
#(
    parameter int             NUM_REQ      = 3,
    parameter int             DATA_WIDTH   = 59,
    parameter int             FIFO_DEPTH   = 32,
    parameter int             CNT_WIDTH    = 6,
    parameter int             CREDIT_WIDTH = 8,
    parameter logic [CREDIT_WIDTH-1:0] INIT_CREDITS = '0
) (
    input wire logic              clock,
    input wire logic              reset,
    ocx_tlx_rsp_fifo_ctl_if.slave bus
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_SUM_W = CREDIT_WIDTH + 2;
    localparam logic [c_SUM_W-1:0] c_CREDIT_MAX = {2'b00, {CREDIT_WIDTH{1'b1}}};

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic                  w_space;
    logic [NUM_REQ-1:0]    w_grant;
    logic [IDX_W-1:0]      w_grant_idx;
    logic                  w_grant_valid;
    logic [DATA_WIDTH-1:0] w_wr_data;

    // Occupancy only; a pop in the same cycle does not free a slot early.
    assign w_space = (bus.fifo_valid_entry_count < CNT_WIDTH'(FIFO_DEPTH));

    ocx_tlx_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clock       (clock),
        .reset       (reset),
        .req         (bus.req_valid),
        .enable      (w_space),
        .grant       (w_grant),
        .grant_idx   (w_grant_idx),
        .grant_valid (w_grant_valid)
    );

    // One-hot AND-OR mux of the winning requester's data
    always_comb begin
        w_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_wr_data = w_wr_data | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read state machine
    // ------------------------------------------------------------------
    rsp_state_t              r_state;
    rsp_state_t              w_state_nxt;
    logic [CREDIT_WIDTH-1:0] r_credits;
    logic                    w_rd_done;
    logic                    w_in_present;

    assign w_in_present = (r_state == ST_PRESENT);
    assign w_rd_done    = w_in_present & bus.rsp_taken;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.rsp_halt) begin
                    w_state_nxt = ST_HALT;
                end else if (bus.fifo_data_available && (r_credits != '0)) begin
                    w_state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                // Halt is only honoured once the presented entry is taken.
                if (bus.rsp_taken) begin
                    if ((bus.fifo_valid_entry_count > CNT_WIDTH'(1)) &&
                        (r_credits > CREDIT_WIDTH'(1)) && !bus.rsp_halt) begin
                        w_state_nxt = ST_PRESENT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_HALT: begin
                if (!bus.rsp_halt) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Credit counter: two spare MSBs catch both overflow and a negative
    // result, so the return and the consume can be applied together.
    // ------------------------------------------------------------------
    logic [c_SUM_W-1:0]      w_credit_sum;
    logic [CREDIT_WIDTH-1:0] w_credits_nxt;
    logic                    w_credit_sat;

    always_comb begin
        w_credit_sum  = {2'b00, r_credits}
                      + (bus.tl_credit_return ? c_SUM_W'(bus.tl_credit_count) : '0)
                      - (w_rd_done ? c_SUM_W'(1) : '0);
        w_credit_sat  = 1'b0;
        w_credits_nxt = w_credit_sum[CREDIT_WIDTH-1:0];
        if (w_credit_sum[c_SUM_W-1]) begin
            w_credits_nxt = '0;
        end else if (w_credit_sum > c_CREDIT_MAX) begin
            w_credits_nxt = '1;
            w_credit_sat  = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_credits <= INIT_CREDITS;
        end else begin
            r_credits <= w_credits_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sticky errors
    // ------------------------------------------------------------------
    logic [c_ERR_W-1:0] r_err;
    logic [c_ERR_W-1:0] w_err_set;

    always_comb begin
        w_err_set                       = '0;
        w_err_set[c_ERR_FIFO_UNDERFLOW] = bus.fifo_underflow_error;
        w_err_set[c_ERR_FIFO_OVERFLOW]  = bus.fifo_overflow_error;
        w_err_set[c_ERR_CREDIT_OVFL]    = w_credit_sat;
        w_err_set[c_ERR_TAKEN_NO_VALID] = bus.rsp_taken & ~w_in_present;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err <= '0;
        end else begin
            r_err <= r_err | w_err_set;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ack        = w_grant;
    assign bus.fifo_wr_enable = w_grant_valid;
    assign bus.fifo_data_in   = w_wr_data;
    assign bus.fifo_rd_done   = w_rd_done;
    assign bus.rsp_valid      = w_in_present;
    assign bus.rsp_data       = bus.fifo_data_out;
    assign bus.credits_avail  = r_credits;
    assign bus.err_sticky     = r_err;

endmodule : ocx_tlx_rsp_fifo_ctl
`default_nettype wire

// File: tb/tb_ocx_tlx_rsp_fifo_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ocx_tlx_rsp_fifo_ctl
// Description : Directed self-checking bench for ocx_tlx_rsp_fifo_ctl. A
//               behavioural 32-deep FIFO sits on the write/read ports;
//               expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ocx_tlx_rsp_fifo_ctl;

    localparam int c_NREQ = 3;
    localparam int c_DW   = 59;
    localparam int c_CW   = 6;
    localparam int c_CRW  = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clock = ~clock;

    ocx_tlx_rsp_fifo_ctl_if #(
        .NUM_REQ(c_NREQ), .DATA_WIDTH(c_DW), .CNT_WIDTH(c_CW), .CREDIT_WIDTH(c_CRW)
    ) bus ();

    ocx_tlx_rsp_fifo_ctl #(
        .NUM_REQ(c_NREQ), .DATA_WIDTH(c_DW), .FIFO_DEPTH(32),
        .CNT_WIDTH(c_CW), .CREDIT_WIDTH(c_CRW), .INIT_CREDITS(8'd0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural FIFO with asynchronous head read
    logic [c_DW-1:0] q[$];
    logic [c_CW-1:0] m_count = '0;
    logic [c_DW-1:0] m_head  = '0;

    always @(posedge clock) begin
        if (bus.fifo_wr_enable) q.push_back(bus.fifo_data_in);
        if (bus.fifo_rd_done && q.size() > 0) void'(q.pop_front());
        m_count <= c_CW'(q.size());
        m_head  <= (q.size() > 0) ? q[0] : '0;
    end

    assign bus.fifo_valid_entry_count = m_count;
    assign bus.fifo_data_available    = (m_count != '0);
    assign bus.fifo_data_out          = m_head;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_data(input logic [c_DW-1:0] d0, input logic [c_DW-1:0] d1,
                            input logic [c_DW-1:0] d2);
        bus.req_data = {d2, d1, d0};
    endtask

    initial begin
        bus.req_valid            = '0;
        bus.req_data             = '0;
        bus.fifo_underflow_error = 1'b0;
        bus.fifo_overflow_error  = 1'b0;
        bus.tl_credit_return     = 1'b0;
        bus.tl_credit_count      = 4'd0;
        bus.rsp_halt             = 1'b0;
        bus.rsp_taken            = 1'b0;

        // ---------------- reset state ----------------
        @(negedge clock); @(negedge clock); #1;
        chk("rst_valid",   64'(bus.rsp_valid), 64'd0);
        chk("rst_credits", 64'(bus.credits_avail), 64'd0);
        chk("rst_err",     64'(bus.err_sticky), 64'd0);
        chk("rst_ack",     64'(bus.req_ack), 64'd0);
        chk("rst_wr",      64'(bus.fifo_wr_enable), 64'd0);
        reset = 1'b0;

        // ---------------- 1: single write, credit gating ----------------
        @(negedge clock);
        set_data(59'hA1, 59'h0, 59'h0);
        bus.req_valid = 3'b001; #1;
        chk("t1_ack", 64'(bus.req_ack), 64'b001);
        chk("t1_wr",  64'(bus.fifo_wr_enable), 64'd1);
        chk("t1_din", 64'(bus.fifo_data_in), 64'hA1);
        @(negedge clock);
        bus.req_valid = '0;
        bus.tl_credit_return = 1'b1; bus.tl_credit_count = 4'd2; #1;
        chk("t1_nocred_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clock);
        bus.tl_credit_return = 1'b0; #1;
        chk("t1_credits", 64'(bus.credits_avail), 64'd2);
        chk("t1_valid_lat1", 64'(bus.rsp_valid), 64'd0);
        @(negedge clock); #1;
        chk("t1_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t1_data",  64'(bus.rsp_data), 64'hA1);
        bus.rsp_taken = 1'b1; #1;
        chk("t1_rd", 64'(bus.fifo_rd_done), 64'd1);
        @(negedge clock);
        bus.rsp_taken = 1'b0; #1;
        chk("t1_idle", 64'(bus.rsp_valid), 64'd0);
        chk("t1_cred_after", 64'(bus.credits_avail), 64'd1);

        // ---------------- 2: round robin order ----------------
        @(negedge clock);                     // move pointer to 0
        set_data(59'h100, 59'h101, 59'h102);
        bus.req_valid = 3'b100; #1;
        chk("t2_pre_ack", 64'(bus.req_ack), 64'b100);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            bus.req_valid = 3'b111; #1;
            chk("t2_ack", 64'(bus.req_ack), 64'(3'b001 << (k % 3)));
            chk("t2_din", 64'(bus.fifo_data_in), 64'h100 + 64'(k % 3));
        end

        // ---------------- 3: full FIFO blocks grant ----------------
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            set_data(59'h200 + 59'(i), 59'h101, 59'h102);
            bus.req_valid = 3'b001;
        end
        @(negedge clock);
        set_data(59'h300, 59'h101, 59'h102);
        bus.rsp_taken = 1'b1; #1;
        chk("t3_count", 64'(m_count), 64'd32);
        chk("t3_full_ack", 64'(bus.req_ack), 64'd0);
        chk("t3_full_wr",  64'(bus.fifo_wr_enable), 64'd0);
        chk("t3_pop",      64'(bus.fifo_rd_done), 64'd1);
        chk("t3_head",     64'(bus.rsp_data), 64'h102);
        @(negedge clock);
        bus.rsp_taken = 1'b0; #1;
        chk("t3_resume_ack", 64'(bus.req_ack), 64'b001);
        chk("t3_resume_din", 64'(bus.fifo_data_in), 64'h300);
        chk("t3_cred0",      64'(bus.credits_avail), 64'd0);
        chk("t3_valid0",     64'(bus.rsp_valid), 64'd0);

        // ---------------- 4: credit-limited burst ----------------
        @(negedge clock);
        bus.req_valid = '0;
        bus.tl_credit_return = 1'b1; bus.tl_credit_count = 4'd3;
        @(negedge clock);
        bus.tl_credit_return = 1'b0; #1;
        chk("t4_credits", 64'(bus.credits_avail), 64'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            bus.rsp_taken = 1'b1; #1;
            chk("t4_valid", 64'(bus.rsp_valid), 64'd1);
            chk("t4_rd",    64'(bus.fifo_rd_done), 64'd1);
            chk("t4_data",  64'(bus.rsp_data), 64'h100 + 64'(k));
        end
        @(negedge clock);
        bus.rsp_taken = 1'b0; #1;
        chk("t4_drop",   64'(bus.rsp_valid), 64'd0);
        chk("t4_cred0",  64'(bus.credits_avail), 64'd0);

        // ---------------- 5: halt while presenting ----------------
        bus.tl_credit_return = 1'b1; bus.tl_credit_count = 4'd2;
        @(negedge clock);
        bus.tl_credit_return = 1'b0;
        @(negedge clock); #1;
        chk("t5_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t5_data",  64'(bus.rsp_data), 64'h100);
        bus.rsp_halt = 1'b1;
        @(negedge clock); #1;
        chk("t5_hold", 64'(bus.rsp_valid), 64'd1);
        @(negedge clock);
        bus.rsp_taken = 1'b1; #1;
        chk("t5_hold2", 64'(bus.rsp_valid), 64'd1);
        chk("t5_rd",    64'(bus.fifo_rd_done), 64'd1);
        @(negedge clock);
        bus.rsp_taken = 1'b0; #1;
        chk("t5_idle", 64'(bus.rsp_valid), 64'd0);
        @(negedge clock); #1;
        chk("t5_halted", 64'(bus.rsp_valid), 64'd0);
        @(negedge clock); #1;
        chk("t5_halted2", 64'(bus.rsp_valid), 64'd0);
        bus.rsp_halt = 1'b0;
        @(negedge clock); #1;
        chk("t5_back_idle", 64'(bus.rsp_valid), 64'd0);
        @(negedge clock); #1;
        chk("t5_represent", 64'(bus.rsp_valid), 64'd1);
        chk("t5_data2",     64'(bus.rsp_data), 64'h101);
        bus.rsp_taken = 1'b1;
        @(negedge clock);
        bus.rsp_taken = 1'b0; #1;
        chk("t5_cred0", 64'(bus.credits_avail), 64'd0);

        // ---------------- 6: saturation, stray taken, errors, reset ----------------
        bus.rsp_halt = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            bus.tl_credit_return = 1'b1; bus.tl_credit_count = 4'd15;
        end
        @(negedge clock);
        bus.tl_credit_count = 4'd10;
        @(negedge clock);
        bus.tl_credit_return = 1'b0; #1;
        chk("t6_cred250", 64'(bus.credits_avail), 64'd250);
        chk("t6_err_pre", 64'(bus.err_sticky), 64'd0);
        bus.tl_credit_return = 1'b1; bus.tl_credit_count = 4'd15;
        @(negedge clock);
        bus.tl_credit_return = 1'b0; #1;
        chk("t6_cred_sat", 64'(bus.credits_avail), 64'd255);
        chk("t6_err_sat",  64'(bus.err_sticky), 64'b0100);
        bus.rsp_halt = 1'b0;
        @(negedge clock);
        bus.rsp_taken = 1'b1; #1;
        chk("t6_stray_rd",    64'(bus.fifo_rd_done), 64'd0);
        chk("t6_stray_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clock);
        bus.rsp_taken = 1'b0; #1;
        chk("t6_err_taken", 64'(bus.err_sticky), 64'b1100);
        chk("t6_present",   64'(bus.rsp_valid), 64'd1);
        bus.fifo_underflow_error = 1'b1;
        bus.fifo_overflow_error  = 1'b1;
        @(negedge clock);
        bus.fifo_underflow_error = 1'b0;
        bus.fifo_overflow_error  = 1'b0; #1;
        chk("t6_err_all", 64'(bus.err_sticky), 64'b1111);
        #2 reset = 1'b1; #1;
        chk("t6_rst_valid",   64'(bus.rsp_valid), 64'd0);
        chk("t6_rst_credits", 64'(bus.credits_avail), 64'd0);
        chk("t6_rst_err",     64'(bus.err_sticky), 64'd0);
        chk("t6_rst_rd",      64'(bus.fifo_rd_done), 64'd0);
        chk("t6_rst_ack",     64'(bus.req_ack), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ocx_tlx_rsp_fifo_ctl
`default_nettype wire
